vote_result_tx: RTL and testbench

// - Downstream reader of the voting machine's tally outputs.
// - On voting close, snapshots the three candidate counts and decides the winner or a tie.
// - Serialises a result frame over a UART-style 8N1 line to the display/logging unit.

---
 rtl/vote_result_tx.sv | 220 ++++++++++++++++++++++
 tb/tb_vote_result_tx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_result_tx.sv
// vote_result_tx: snapshots the three candidate tallies when voting closes,
// decides winner/tie and sends the result as a UART 8N1 frame.
// Optional build macro VOTE_TX_CHECKSUM_EN appends an XOR checksum byte.
module vote_result_tx #(
    parameter int unsigned COUNT_W      = 6,
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_voting_over,
    input  logic [COUNT_W-1:0] i_count1,
    input  logic [COUNT_W-1:0] i_count2,
    input  logic [COUNT_W-1:0] i_count3,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_done,
    output logic [1:0]         o_winner,
    output logic               o_tie
);

    localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);
`ifdef VOTE_TX_CHECKSUM_EN
    localparam int unsigned NBYTES = 6;
`else
    localparam int unsigned NBYTES = 5;
`endif
    localparam logic [2:0]       LAST_BYTE = 3'(NBYTES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [2:0]       bit_q, bit_d;
    logic [2:0]       byte_q, byte_d;
    logic             vo_q;
    logic [7:0]       c1_q, c1_d;
    logic [7:0]       c2_q, c2_d;
    logic [7:0]       c3_q, c3_d;
    logic [1:0]       win_q, win_d;
    logic             tie_q, tie_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [7:0] cnt1_ext, cnt2_ext, cnt3_ext;
    logic [1:0] win_c;
    logic       tie_c;
    logic [7:0] win_byte;
    logic [7:0] cur_byte;
    logic       trigger;
    logic       bit_end;

    assign cnt1_ext = 8'(i_count1);
    assign cnt2_ext = 8'(i_count2);
    assign cnt3_ext = 8'(i_count3);
    assign trigger  = i_voting_over & ~vo_q;
    assign bit_end  = (timer_q == TMR_MAX);
    assign win_byte = {tie_q, 5'b0, win_q};

    // Unique strict maximum wins; shared maximum or all-zero falls through to a tie.
    always_comb begin
        win_c = 2'd0;
        tie_c = 1'b0;
        if ((cnt1_ext > cnt2_ext) && (cnt1_ext > cnt3_ext)) begin
            win_c = 2'd1;
        end else if ((cnt2_ext > cnt1_ext) && (cnt2_ext > cnt3_ext)) begin
            win_c = 2'd2;
        end else if ((cnt3_ext > cnt1_ext) && (cnt3_ext > cnt2_ext)) begin
            win_c = 2'd3;
        end else begin
            tie_c = 1'b1;
        end
    end

    // Select the frame byte currently on the line.
    always_comb begin
        cur_byte = HEADER;
        case (byte_q)
            3'd0:    cur_byte = HEADER;
            3'd1:    cur_byte = c1_q;
            3'd2:    cur_byte = c2_q;
            3'd3:    cur_byte = c3_q;
            3'd4:    cur_byte = win_byte;
`ifdef VOTE_TX_CHECKSUM_EN
            3'd5:    cur_byte = HEADER ^ c1_q ^ c2_q ^ c3_q ^ win_byte;
`endif
            default: cur_byte = HEADER;
        endcase
    end

    // Next-state and registered-output logic for the serialiser.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
        c3_d    = c3_q;
        win_d   = win_q;
        tie_d   = tie_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                // Line is free in both states, so a fresh edge is accepted here.
                if (trigger) begin
                    state_d = S_START;
                    timer_d = '0;
                    bit_d   = 3'd0;
                    byte_d  = 3'd0;
                    c1_d    = cnt1_ext;
                    c2_d    = cnt2_ext;
                    c3_d    = cnt3_ext;
                    win_d   = win_c;
                    tie_d   = tie_c;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    timer_d = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                    tx_d    = cur_byte[0];
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte[bit_q + 3'd1];
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (byte_q == LAST_BYTE) begin
                        state_d = S_DONE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, snapshot and output registers; reset drops the frame and idles the line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 3'd0;
            vo_q    <= 1'b0;
            c1_q    <= 8'd0;
            c2_q    <= 8'd0;
            c3_q    <= 8'd0;
            win_q   <= 2'd0;
            tie_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            vo_q    <= i_voting_over;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            c3_q    <= c3_d;
            win_q   <= win_d;
            tie_q   <= tie_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_tx     = tx_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_winner = win_q;
    assign o_tie    = tie_q;

endmodule

// File: tb/tb_vote_result_tx.sv
// Bench for vote_result_tx: a line-level reference model checked every cycle,
// plus directed frames decoded by mid-bit sampling against hand-computed bytes.
module tb_vote_result_tx;

    localparam int CPB = 10;
    localparam int CW  = 6;
`ifdef VOTE_TX_CHECKSUM_EN
    localparam int NB       = 6;
    localparam int EXP_DONE = 601;
`else
    localparam int NB       = 5;
    localparam int EXP_DONE = 501;
`endif
    localparam int FRAME_CYC = NB * 10 * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          vo  = 1'b0;
    logic [CW-1:0] c1  = '0;
    logic [CW-1:0] c2  = '0;
    logic [CW-1:0] c3  = '0;
    logic          tx, busy, done, tie;
    logic [1:0]    win;

    always #5 clk = ~clk;

    vote_result_tx #(
        .COUNT_W     (CW),
        .CLKS_PER_BIT(CPB),
        .HEADER      (8'hA5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_voting_over(vo),
        .i_count1     (c1),
        .i_count2     (c2),
        .i_count3     (c3),
        .o_tx         (tx),
        .o_busy       (busy),
        .o_done       (done),
        .o_winner     (win),
        .o_tie        (tie)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: queue of expected line levels ----------------
    bit mq[$];
    bit m_done = 1'b0;
    bit m_prev = 1'b0;
    int m_win  = 0;
    bit m_tie  = 1'b0;

    function automatic void start_frame(input int a, input int b, input int c);
        int cnt[3];
        int mx;
        int nmax;
        int widx;
        logic [7:0] by[6];
        cnt  = '{a, b, c};
        mx   = 0;
        widx = 0;
        for (int i = 0; i < 3; i++) if (cnt[i] > mx) begin mx = cnt[i]; widx = i; end
        nmax = 0;
        for (int i = 0; i < 3; i++) if (cnt[i] == mx) nmax++;
        if (mx == 0 || nmax > 1) begin
            m_tie = 1'b1;
            m_win = 0;
        end else begin
            m_tie = 1'b0;
            m_win = widx + 1;
        end
        by[0] = 8'hA5;
        by[1] = a[7:0];
        by[2] = b[7:0];
        by[3] = c[7:0];
        by[4] = {m_tie, 5'b0, 2'(m_win)};
        by[5] = by[0] ^ by[1] ^ by[2] ^ by[3] ^ by[4];
        for (int k = 0; k < NB; k++) begin
            for (int t = 0; t < CPB; t++) mq.push_back(1'b0);
            for (int j = 0; j < 8; j++)
                for (int t = 0; t < CPB; t++) mq.push_back(by[k][j]);
            for (int t = 0; t < CPB; t++) mq.push_back(1'b1);
        end
    endfunction

    always @(posedge clk or negedge rst) begin : model
        bit was_busy;
        if (!rst) begin
            mq.delete();
            m_done = 1'b0;
            m_prev = 1'b0;
            m_win  = 0;
            m_tie  = 1'b0;
        end else begin
            was_busy = (mq.size() > 0);
            m_done   = 1'b0;
            if (was_busy) begin
                void'(mq.pop_front());
                if (mq.size() == 0) m_done = 1'b1;
            end
            if (vo && !m_prev && !was_busy) start_frame(int'(c1), int'(c2), int'(c3));
            m_prev = vo;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("cyc_tx",     32'(tx),   (mq.size() > 0) ? 32'(mq[0]) : 32'd1);
        check("cyc_busy",   32'(busy), 32'(mq.size() > 0));
        check("cyc_done",   32'(done), 32'(m_done));
        check("cyc_winner", 32'(win),  32'(m_win));
        check("cyc_tie",    32'(tie),  32'(m_tie));
    end

    // ---------------- directed stimulus ----------------
    logic       line_s[1:700];
    int         done_cnt;
    int         done_cyc;
    logic [7:0] exp_b[6];

    // Trigger at the next edge (cycle 0) and record the line for ncyc cycles.
    // mode 0: drop the level at cycle 3; 1: also change counts and re-pulse mid-frame;
    // 2: hold the level high for the whole window.
    task automatic run(input int ncyc, input int mode);
        done_cnt = 0;
        done_cyc = -1;
        vo = 1'b1;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(negedge clk);
            line_s[cyc] = tx;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (mode != 2 && cyc == 3) vo = 1'b0;
            if (mode == 1) begin
                if (cyc == 100) begin c1 = 6'd1; c2 = 6'd9; c3 = 6'd4; end
                if (cyc == 120) vo = 1'b1;
                if (cyc == 140) vo = 1'b0;
            end
        end
    endtask

    task automatic check_frame(input string tag, input int exp_win, input int exp_tie);
        int base;
        logic [7:0] b;
        logic st, sp;
        bit wbad;
        for (int k = 0; k < NB; k++) begin
            base = 1 + k * 10 * CPB;
            st   = line_s[base + CPB / 2];
            sp   = line_s[base + 9 * CPB + CPB / 2];
            for (int j = 0; j < 8; j++) b[j] = line_s[base + (j + 1) * CPB + CPB / 2];
            wbad = 1'b0;
            for (int j = 0; j < 10; j++)
                for (int t = 0; t < CPB; t++)
                    if (line_s[base + j * CPB + t] !== line_s[base + j * CPB + CPB / 2]) wbad = 1'b1;
            check($sformatf("%s_byte%0d", tag, k), 32'(b), 32'(exp_b[k]));
            check($sformatf("%s_framing%0d", tag, k), {30'd0, st, sp}, 32'b01);
            check($sformatf("%s_bitwidth%0d", tag, k), 32'(wbad), 32'd0);
        end
        check({tag, "_done_cycle"}, done_cyc, EXP_DONE);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_winner"}, 32'(win), exp_win);
        check({tag, "_tie"}, 32'(tie), exp_tie);
        check({tag, "_idle_busy"}, 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 1);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_winner", 32'(win), 0);
        check("reset_tie", 32'(tie), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Shared maximum -> tie.
        c1 = 6'd3; c2 = 6'd3; c3 = 6'd2;
        exp_b = '{8'hA5, 8'h03, 8'h03, 8'h02, 8'h80, 8'h27};
        run(FRAME_CYC + 20, 0);
        check_frame("f332", 0, 1);

        // Unique maximum, level held high throughout (no retrigger).
        c1 = 6'd5; c2 = 6'd2; c3 = 6'd1;
        exp_b = '{8'hA5, 8'h05, 8'h02, 8'h01, 8'h01, 8'hA2};
        run(FRAME_CYC + 20, 2);
        check_frame("f521", 1, 0);
        vo = 1'b0;
        @(negedge clk);

        // All zero -> tie.
        c1 = 6'd0; c2 = 6'd0; c3 = 6'd0;
        exp_b = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h80, 8'h25};
        run(FRAME_CYC + 20, 0);
        check_frame("f000", 0, 1);

        // Inputs change and a second pulse arrives while busy.
        c1 = 6'd1; c2 = 6'd4; c3 = 6'd4;
        exp_b = '{8'hA5, 8'h01, 8'h04, 8'h04, 8'h80, 8'h24};
        run(FRAME_CYC + 20, 1);
        check_frame("f144", 0, 1);

        // Reset during byte 2 while the line is low.
        c1 = 6'd2; c2 = 6'd6; c3 = 6'd1;
        run(215, 0);
        check("pre_reset_tx_low", 32'(tx), 0);
        #2 rst = 1'b0;
        #1;
        check("midrst_tx", 32'(tx), 1);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_cnt++;
        end
        check("postrst_quiet", done_cnt, 0);

        // Fresh trigger after release gives a complete frame.
        c1 = 6'd7; c2 = 6'd2; c3 = 6'd9;
        exp_b = '{8'hA5, 8'h07, 8'h02, 8'h09, 8'h03, 8'hAA};
        run(FRAME_CYC + 20, 0);
        check_frame("f729", 3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
